// File: rtl/distribute_pkg.sv
// Shared constants for the distribute switch: drop-counter width, the "no destination"
// mask value and the saturating increment used by the drop counter.
package distribute_pkg;

    localparam int DROP_CNT_W = 16;

    // Wide enough for the largest supported NUM_OUT; users slice it to their width.
    localparam logic [15:0] NA_MASK = '0;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (value == '1) ? value : value + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/distribute_switch_buf_sync_fifo.sv
// Single-clock FIFO for one output channel: power-of-two depth, wrapping pointers,
// explicit occupancy counter and a combinational head read.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is ignored even if it pops the same cycle; the
    // caller never offers one because its ready looks only at registered occupancy.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an empty FIFO never exposes it because the top zeroes the slice.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/distribute_switch_buf.sv
// Multicast switch: one input word is copied into every output FIFO selected by the
// destination mask, all-or-nothing; zero-mask words are counted and discarded.
module distribute_switch_buf
    import distribute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_data_bus,
    input  logic [NUM_OUT-1:0]            i_cmd,
    input  logic                          i_en,
    output logic                          o_ready,
    output logic [NUM_OUT-1:0]            o_valid,
    output logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus,
    input  logic [NUM_OUT-1:0]            i_ready,
    output logic [DROP_CNT_W-1:0]         o_drop_cnt
);

    logic [NUM_OUT-1:0]    fifo_full;
    logic [NUM_OUT-1:0]    fifo_empty;
    logic [NUM_OUT-1:0]    fifo_push;
    logic [NUM_OUT-1:0]    fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head [NUM_OUT];
    logic                  accept;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Ready depends only on registered fullness of the targeted FIFOs, so a pop in the
    // same cycle cannot open a slot early and there is no input-to-output comb path.
    assign o_ready   = i_en & ~|(i_cmd & fifo_full);
    assign accept    = i_valid & o_ready;
    assign fifo_push = accept ? i_cmd : '0;
    assign fifo_pop  = ~fifo_empty & i_ready;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        sync_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (fifo_push[g]),
            .pop_i  (fifo_pop[g]),
            .data_i (i_data_bus),
            .full_o (fifo_full[g]),
            .empty_o(fifo_empty[g]),
            .head_o (fifo_head[g])
        );

        assign o_valid[g] = ~fifo_empty[g];
        assign o_data_bus[g*DATA_WIDTH +: DATA_WIDTH] =
            fifo_empty[g] ? '0 : fifo_head[g];
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && (i_cmd == NA_MASK[NUM_OUT-1:0])) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_distribute_switch_buf.sv
// Self-checking bench for distribute_switch_buf (2 outputs, depth 2, 32-bit words),
// using a queue-per-output scoreboard advanced once per clock.
module tb_distribute_switch_buf;

    localparam int DW    = 32;
    localparam int NO    = 2;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid;
    logic [DW-1:0]   i_data_bus;
    logic [NO-1:0]   i_cmd;
    logic            i_en;
    logic            o_ready;
    logic [NO-1:0]   o_valid;
    logic [NO*DW-1:0] o_data_bus;
    logic [NO-1:0]   i_ready;
    logic [15:0]     o_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q [NO][$];
    logic [15:0]   exp_drop = '0;

    distribute_switch_buf #(
        .DATA_WIDTH(DW),
        .NUM_OUT   (NO),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_data_bus(i_data_bus),
        .i_cmd     (i_cmd),
        .i_en      (i_en),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_data_bus(o_data_bus),
        .i_ready   (i_ready),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock: compare DUT against the scoreboard at the falling edge, then apply
    // the rising-edge effects (pops, pushes, drops, reset) to the scoreboard.
    task automatic tick();
        logic          exp_ready;
        logic [NO-1:0] exp_valid;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        exp_ready = i_en;
        for (int k = 0; k < NO; k++) begin
            if (i_cmd[k] && exp_q[k].size() == DEPTH) exp_ready = 1'b0;
            exp_valid[k] = (exp_q[k].size() != 0);
        end
        n_cmp++;
        if (o_ready !== exp_ready) begin
            n_err++;
            $display("FAIL sb_ready t=%0t got=%b exp=%b", $time, o_ready, exp_ready);
        end
        n_cmp++;
        if (o_valid !== exp_valid) begin
            n_err++;
            $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, o_valid, exp_valid);
        end
        for (int k = 0; k < NO; k++) begin
            exp_d = exp_valid[k] ? exp_q[k][0] : '0;
            n_cmp++;
            if (o_data_bus[k*DW +: DW] !== exp_d) begin
                n_err++;
                $display("FAIL sb_data%0d t=%0t got=%h exp=%h", k, $time, o_data_bus[k*DW +: DW], exp_d);
            end
        end
        n_cmp++;
        if (o_drop_cnt !== exp_drop) begin
            n_err++;
            $display("FAIL sb_drop t=%0t got=%0d exp=%0d", $time, o_drop_cnt, exp_drop);
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < NO; k++) exp_q[k].delete();
            exp_drop = '0;
        end else begin
            for (int k = 0; k < NO; k++) begin
                if (exp_valid[k] && i_ready[k]) void'(exp_q[k].pop_front());
            end
            if (i_valid && exp_ready) begin
                if (i_cmd == '0) begin
                    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
                end else begin
                    for (int k = 0; k < NO; k++) begin
                        if (i_cmd[k]) exp_q[k].push_back(i_data_bus);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = '1;
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_cmd = '0; i_en = 1'b1; i_ready = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 2'b00 || o_data_bus !== '0 || o_drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state valid=%b data=%h drop=%0d exp 0/0/0", o_valid, o_data_bus, o_drop_cnt);
        end
        expect_bit("reset_ready", o_ready, 1'b1);
        tick();
    endtask

    task automatic test_broadcast();
        i_ready = 2'b11; i_valid = 1'b1; i_data_bus = 32'hA5A5_0001; i_cmd = 2'b11;
        tick();
        i_valid = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 2'b11 || o_data_bus !== {2{32'hA5A5_0001}}) begin
            n_err++;
            $display("FAIL bcast_out valid=%b data=%h exp 11/%h", o_valid, o_data_bus, {2{32'hA5A5_0001}});
        end
        tick();
        n_cmp++;
        if (o_valid !== 2'b00) begin
            n_err++;
            $display("FAIL bcast_pop valid=%b exp=00", o_valid);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 2'b00; i_cmd = 2'b01; i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data_bus = 32'h0000_0B00 + DW'(i);
            #1;
            if (i == 2) expect_bit("bp_third_ready", o_ready, 1'b0);
            tick();
        end
        i_valid = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 2'b01 || o_data_bus[DW +: DW] !== '0) begin
            n_err++;
            $display("FAIL bp_state valid=%b slice1=%h exp 01/0", o_valid, o_data_bus[DW +: DW]);
        end
        drain();
    endtask

    task automatic test_partial_full();
        i_ready = 2'b00; i_cmd = 2'b01; i_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_data_bus = 32'h0000_0C00 + DW'(i);
            tick();
        end
        i_cmd = 2'b10; i_data_bus = 32'h0000_0C10;
        #1;
        expect_bit("pf_mask10_ready", o_ready, 1'b1);
        tick();
        i_cmd = 2'b11; i_data_bus = 32'h0000_0C11;
        #1;
        expect_bit("pf_mask11_ready", o_ready, 1'b0);
        tick();
        drain();
    endtask

    task automatic test_wrap();
        i_ready = 2'b00; i_cmd = 2'b01; i_valid = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            i_data_bus = DW'(i);
            tick();
        end
        i_ready = 2'b01; i_data_bus = 32'd3;
        #1;
        expect_bit("wrap_full_pop_ready", o_ready, 1'b0);
        tick();
        #1;
        expect_bit("wrap_next_ready", o_ready, 1'b1);
        tick();
        drain();
    endtask

    task automatic test_drop_and_enable();
        i_ready = 2'b11; i_cmd = 2'b00; i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data_bus = 32'hD0D0_0000 + DW'(i);
            tick();
        end
        i_valid = 1'b0;
        #1;
        n_cmp++;
        if (o_drop_cnt !== 16'd5 || o_valid !== 2'b00) begin
            n_err++;
            $display("FAIL drop_cnt got=%0d valid=%b exp 5/00", o_drop_cnt, o_valid);
        end
        i_ready = 2'b00; i_cmd = 2'b11; i_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_data_bus = 32'hE000_0000 + DW'(i);
            tick();
        end
        i_en = 1'b0; i_ready = 2'b11; i_data_bus = 32'hE000_00FF;
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_bit("en_off_ready", o_ready, 1'b0);
            tick();
        end
        n_cmp++;
        if (o_valid !== 2'b00) begin
            n_err++;
            $display("FAIL en_off_drain valid=%b exp=00", o_valid);
        end
        i_en = 1'b1; i_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        i_ready = 2'b00; i_cmd = 2'b11; i_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_data_bus = 32'hF000_0000 + DW'(i);
            tick();
        end
        i_valid = 1'b0; i_ready = 2'b11; rst_n = 1'b0;
        tick();
        n_cmp++;
        if (o_valid !== 2'b00 || o_drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset valid=%b drop=%0d exp 00/0", o_valid, o_drop_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (o_valid !== 2'b00) begin
                n_err++;
                $display("FAIL mid_reset_emit valid=%b exp=00", o_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_backpressure();
        test_partial_full();
        test_wrap();
        test_drop_and_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/distribute_switch_buf.md
DISTRIBUTE_SWITCH_BUF -- requirements
Module: distribute_switch_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 Parameter NUM_OUT, default 2, number of output channels (2..16).
REQ-003 Parameter FIFO_DEPTH, default 2, entries per output FIFO (power of two, >=2).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port i_valid  input  1  input word valid.
REQ-007 Port i_data_bus  input  DATA_WIDTH  input word.
REQ-008 Port i_cmd  input  NUM_OUT  destination mask, bit k targets output k; mask all ones = broadcast, mask zero = NA.
REQ-009 Port i_en  input  1  switch enable.
REQ-010 Port o_ready  output  1  switch can accept the current input word.
REQ-011 Port o_valid  output  NUM_OUT  per-output valid.
REQ-012 Port o_data_bus  output  NUM_OUT*DATA_WIDTH  output k at slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 Port i_ready  input  NUM_OUT  per-output downstream ready.
REQ-014 Port o_drop_cnt  output  16  count of accepted words with zero mask.

Function
REQ-015 o_ready SHALL equal i_en AND (no FIFO k with i_cmd[k]=1 is full), full taken from registered occupancy only.
REQ-016 Accept SHALL occur in a cycle with i_valid & o_ready; on accept the word SHALL be pushed into every FIFO k with i_cmd[k]=1, in the same edge (all-or-nothing multicast).
REQ-017 Accept with i_cmd=0 SHALL push nothing and increment o_drop_cnt, saturating at 16'hFFFF.
REQ-018 o_valid[k] SHALL equal FIFO k non-empty; output slice k SHALL be FIFO k head, and {DATA_WIDTH{1'b0}} when o_valid[k]=0.
REQ-019 Pop of FIFO k SHALL occur when o_valid[k] & i_ready[k]; outputs pop independently.
REQ-020 Latency: word accepted at edge N SHALL appear on o_valid/o_data_bus of targeted outputs after edge N; no combinational input-to-output path.
REQ-021 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged and preserve order.
REQ-022 A full FIFO popping in the same cycle SHALL NOT enable a push that cycle (o_ready stays low for masks targeting it).
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits.
REQ-024 i_en=0 SHALL force o_ready=0 and block accepts; FIFOs SHALL continue to drain.
REQ-025 Per-output word order SHALL equal acceptance order.

Reset
REQ-026 While rst_n=0 at an edge: all FIFOs empty, pointers zero, o_drop_cnt=0.
REQ-027 After reset: o_valid=0, o_data_bus=0, o_ready=i_en (all FIFOs empty).
REQ-028 Reset mid-operation SHALL discard all buffered words without emitting them.

Structure
REQ-029 Shared package distribute_pkg SHALL hold the drop-counter width (16) and the NA mask constant (all zeros).
REQ-030 Per-output buffering SHALL be one sub-module sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH; push, pop, full, empty, head), instantiated NUM_OUT times in a generate loop.
REQ-031 Top level SHALL contain only ready/push-mask logic, output zeroing and the drop counter.

Verification (NUM_OUT=2, FIFO_DEPTH=2, DATA_WIDTH=32)
REQ-032 Reset, then i_valid=1, data=32'hA5A5_0001, cmd=2'b11, i_ready=2'b11 -> next cycle o_valid=2'b11, both slices 32'hA5A5_0001, popped the following edge.
REQ-033 i_ready=2'b00, three words cmd=2'b01 -> first two accepted, o_ready=0 on third; o_valid=2'b01; o_valid[1]=0 with slice 1 = 0.
REQ-034 Output 0 full, output 1 empty: cmd=2'b10 -> accepted; cmd=2'b11 -> o_ready=0, nothing pushed to either FIFO.
REQ-035 Output 0 full with i_ready[0]=1 and cmd=2'b01 -> no accept that cycle; accept next cycle; order 1,2,3 preserved after pointer wrap.
REQ-036 Five accepts with cmd=2'b00 -> o_drop_cnt=5, o_valid stays 0; i_en=0 -> o_ready=0 while FIFOs drain.
REQ-037 Assert rst_n=0 with both FIFOs holding 2 words -> after edge o_valid=0, o_drop_cnt=0, no buffered word ever emitted.
